asteroid_spawner: RTL and testbench
===================================

ASTEROID_SPAWNER -- requirements
Module: asteroid_spawner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 251250, clk cycles per delay tick (same rate as asteroid step).
REQ-002 SHALL have parameter X_EXIT, default 640, xmovaddr value at which the asteroid has left the screen.
REQ-003 SHALL have parameter MIN_GAP, default 16, minimum idle ticks between asteroids.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 halt  input  1  game paused/over; 1 freezes all state, counters and LFSR.
REQ-009 xmovaddr  input  10  current asteroid x offset from the asteroid mover.
REQ-010 collide  input  1  dino/asteroid overlap from the renderer, level-sensitive.
REQ-011 asteroid_on  output  1  enable to the asteroid mover; 0 forces mover position to 0.
REQ-012 lane  output  2  y-lane select of the current asteroid, stable while asteroid_on=1.
REQ-013 hit  output  1  one-cycle pulse on collision entry.
REQ-014 passed_count  output  8  asteroids that exited without collision, wraps 255->0.

Function
REQ-015 SHALL implement FSM states WAIT, ACTIVE, RETIRE, HIT; state output encoding internal.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1; tick asserts for one cycle when prescaler==TICK_DIV-1, then prescaler returns to 0; prescaler runs only in WAIT.
REQ-017 WAIT: asteroid_on=0; gap counter decrements on each tick; on tick with gap==1 (or gap==0 on entry) SHALL go to ACTIVE next cycle with lane<=lfsr[1:0].
REQ-018 ACTIVE: asteroid_on=1; collide=1 SHALL take priority over exit: go HIT, hit=1 for exactly that transition cycle.
REQ-019 ACTIVE: collide=0 and xmovaddr>=X_EXIT SHALL go RETIRE and increment passed_count by 1 (8-bit wrap).
REQ-020 RETIRE: asteroid_on=0 for exactly one cycle; gap<=MIN_GAP+lfsr[5:0]; prescaler<=0; next state WAIT.
REQ-021 HIT: asteroid_on held 1, lane held; state persists until reset (game over); collide ignored.
REQ-022 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every non-halted cycle; never reaches 0.
REQ-023 halt=1 SHALL hold state, prescaler, gap, LFSR, lane, passed_count; hit forced 0; asteroid_on keeps its value.
REQ-024 halt release SHALL resume exactly where frozen, no skipped or duplicated tick.
REQ-025 Comparison xmovaddr>=X_EXIT unsigned, 10-bit; X_EXIT>1023 never exits (caller error, not checked).
REQ-026 Gap counter width SHALL hold MIN_GAP+63 without overflow.

Reset
REQ-027 reset==0 at a clk edge SHALL set: state WAIT, gap=MIN_GAP, prescaler=0, lfsr=LFSR_SEED, lane=0, passed_count=0, asteroid_on=0, hit=0.
REQ-028 Reset SHALL override halt and any state, including mid-ACTIVE and HIT; asteroid_on drops on the cycle after the reset edge.

Structure
REQ-029 State enum, LFSR tap mask and default X_EXIT/TICK_DIV SHALL live in shared package dino_pkg.
REQ-030 LFSR SHALL be a sub-module lfsr16 (clk, reset, en, seed param, q[15:0]); remainder flat.

Verification (TICK_DIV=4, MIN_GAP=2, X_EXIT=20)
REQ-031 Reset release, halt=0 -> asteroid_on rises exactly 8 cycles later (2 ticks x 4), lane equals lfsr[1:0] at that cycle.
REQ-032 ACTIVE, drive xmovaddr 19 then 20 -> at 20 RETIRE, asteroid_on=0 one cycle, passed_count 0->1, gap=2+lfsr[5:0].
REQ-033 ACTIVE, collide=1 with xmovaddr=20 same cycle -> HIT, hit pulses 1 cycle, passed_count unchanged, asteroid_on stays 1.
REQ-034 halt=1 for 10 cycles mid-WAIT -> prescaler/gap/LFSR frozen; spawn occurs exactly 10 cycles later than unhalted run.
REQ-035 256 clean exits -> passed_count wraps 255->0.
REQ-036 reset=0 for one cycle during HIT -> WAIT, asteroid_on=0, lfsr=16'hACE1, passed_count=0.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game blocks: spawner states,
// LFSR tap mask and default screen/timing parameters.
package dino_pkg;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RETIRE = 2'd2,
      ST_HIT    = 2'd3
   } spawn_state_t;

   // Taps 16,14,13,11 as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned DEFAULT_X_EXIT   = 32'd640;
   localparam int unsigned DEFAULT_TICK_DIV = 32'd251250;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; advances once per enabled cycle, reloads SEED on reset.
module lfsr16
   import dino_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] q
);

   logic [15:0] q_r;

   // Shift register state; a nonzero seed keeps it off the all-zero lockup state
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_r <= SEED;
      end else if (en) begin
         q_r <= lfsr_next(q_r);
      end
   end

   assign q = q_r;

endmodule

// File: rtl/asteroid_spawner.sv
// Asteroid spawner: waits a pseudo-random number of ticks, launches an asteroid
// in a random lane, then retires it on screen exit or latches a game-over hit.
module asteroid_spawner
   import dino_pkg::*;
#(
   parameter int unsigned TICK_DIV  = DEFAULT_TICK_DIV,
   parameter int unsigned X_EXIT    = DEFAULT_X_EXIT,
   parameter int unsigned MIN_GAP   = 32'd16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       halt,
   input  logic [9:0] xmovaddr,
   input  logic       collide,
   output logic       asteroid_on,
   output logic [1:0] lane,
   output logic       hit,
   output logic [7:0] passed_count
);

   localparam int unsigned PRESC_W = $clog2(TICK_DIV + 32'd1);
   localparam int unsigned GAP_W   = $clog2(MIN_GAP + 32'd64);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 32'd1);
   localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(32'd1);
   localparam logic [GAP_W-1:0]   GAP_MIN    = GAP_W'(MIN_GAP);
   localparam logic [GAP_W-1:0]   GAP_ZERO   = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(32'd1);

   // An exit column beyond the 10-bit range can never be reached
   localparam logic       EXIT_NEVER = (X_EXIT > 32'd1023);
   localparam logic [9:0] X_EXIT_10  = EXIT_NEVER ? 10'd0 : X_EXIT[9:0];

   spawn_state_t       state_r, state_nxt_s;
   logic [PRESC_W-1:0] presc_r, presc_nxt_s;
   logic [GAP_W-1:0]   gap_r, gap_nxt_s;
   logic [1:0]         lane_r, lane_nxt_s;
   logic [7:0]         passed_r, passed_nxt_s;
   logic               on_r, on_nxt_s;
   logic               hit_r, hit_nxt_s;
   logic [15:0]        lfsr_q_s;
   logic               tick_s;
   logic               exit_s;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (!halt),
      .q     (lfsr_q_s)
   );

   assign tick_s = (state_r == ST_WAIT) && (presc_r == PRESC_LAST);
   assign exit_s = !EXIT_NEVER && (xmovaddr >= X_EXIT_10);

   // Next-state and next-output logic; halt leaves every default (hold) in place
   always_comb begin
      state_nxt_s  = state_r;
      presc_nxt_s  = presc_r;
      gap_nxt_s    = gap_r;
      lane_nxt_s   = lane_r;
      passed_nxt_s = passed_r;
      on_nxt_s     = on_r;
      hit_nxt_s    = 1'b0;
      if (halt) begin
         hit_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_WAIT: begin
               on_nxt_s = 1'b0;
               if (gap_r == GAP_ZERO) begin
                  state_nxt_s = ST_ACTIVE;
                  lane_nxt_s  = lfsr_q_s[1:0];
                  on_nxt_s    = 1'b1;
                  presc_nxt_s = PRESC_ZERO;
               end else if (tick_s) begin
                  presc_nxt_s = PRESC_ZERO;
                  gap_nxt_s   = gap_r - GAP_ONE;
                  if (gap_r == GAP_ONE) begin
                     state_nxt_s = ST_ACTIVE;
                     lane_nxt_s  = lfsr_q_s[1:0];
                     on_nxt_s    = 1'b1;
                  end else begin
                     state_nxt_s = ST_WAIT;
                  end
               end else begin
                  presc_nxt_s = presc_r + PRESC_ONE;
               end
            end
            ST_ACTIVE: begin
               on_nxt_s = 1'b1;
               // A collision on the exit column still counts as a hit
               if (collide) begin
                  state_nxt_s = ST_HIT;
                  hit_nxt_s   = 1'b1;
               end else if (exit_s) begin
                  state_nxt_s  = ST_RETIRE;
                  passed_nxt_s = passed_r + 8'd1;
                  on_nxt_s     = 1'b0;
               end else begin
                  state_nxt_s = ST_ACTIVE;
               end
            end
            ST_RETIRE: begin
               on_nxt_s    = 1'b0;
               gap_nxt_s   = GAP_MIN + GAP_W'(lfsr_q_s[5:0]);
               presc_nxt_s = PRESC_ZERO;
               state_nxt_s = ST_WAIT;
            end
            ST_HIT: begin
               on_nxt_s    = 1'b1;
               state_nxt_s = ST_HIT;
            end
            default: begin
               state_nxt_s = ST_WAIT;
               on_nxt_s    = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r  <= ST_WAIT;
         presc_r  <= PRESC_ZERO;
         gap_r    <= GAP_MIN;
         lane_r   <= 2'd0;
         passed_r <= 8'd0;
         on_r     <= 1'b0;
         hit_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         presc_r  <= presc_nxt_s;
         gap_r    <= gap_nxt_s;
         lane_r   <= lane_nxt_s;
         passed_r <= passed_nxt_s;
         on_r     <= on_nxt_s;
         hit_r    <= hit_nxt_s;
      end
   end

   assign asteroid_on  = on_r;
   assign lane         = lane_r;
   assign hit          = hit_r;
   assign passed_count = passed_r;

endmodule

// File: tb/tb_asteroid_spawner.sv
// Directed bench for asteroid_spawner with TICK_DIV=4, MIN_GAP=2, X_EXIT=20;
// keeps its own LFSR model to predict lanes and respawn gaps.
module tb_asteroid_spawner;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       halt = 1'b0;
   logic [9:0] xmovaddr = 10'd0;
   logic       collide = 1'b0;
   logic       asteroid_on;
   logic [1:0] lane;
   logic       hit;
   logic [7:0] passed_count;

   int errors = 0;
   int checks = 0;
   logic [15:0] lfsr_m = 16'hACE1;

   asteroid_spawner #(
      .TICK_DIV  (4),
      .X_EXIT    (20),
      .MIN_GAP   (2),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .halt         (halt),
      .xmovaddr     (xmovaddr),
      .collide      (collide),
      .asteroid_on  (asteroid_on),
      .lane         (lane),
      .hit          (hit),
      .passed_count (passed_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock edge; advance the reference LFSR with the inputs seen at that edge
   task automatic cyc();
      @(posedge clk);
      if (!reset) lfsr_m = 16'hACE1;
      else if (!halt) lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   // Counts edges until asteroid_on rises (bounded); lane_exp is the model lfsr[1:0] before that edge
   task automatic wait_spawn(output int n, output logic [1:0] lane_exp);
      n = 0;
      lane_exp = 2'd0;
      while (asteroid_on !== 1'b1 && n < 400) begin
         lane_exp = lfsr_m[1:0];
         cyc();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      halt = 1'b1;
      cyc();
      cyc();
      checks++; if (asteroid_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %0b expected 0", asteroid_on); end
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b expected 0", hit); end
      checks++; if (lane !== 2'd0) begin errors++; $display("FAIL reset_lane: got %0d expected 0", lane); end
      checks++; if (passed_count !== 8'd0) begin errors++; $display("FAIL reset_passed: got %0d expected 0", passed_count); end
      halt = 1'b0;
   endtask

   task automatic test_spawn();
      int n;
      logic [1:0] le;
      do_reset();
      wait_spawn(n, le);
      checks++; if (n !== 8) begin errors++; $display("FAIL spawn_latency: got %0d expected 8", n); end
      checks++; if (lane !== le) begin errors++; $display("FAIL spawn_lane: got %0d expected %0d", lane, le); end
   endtask

   task automatic test_exit();
      int n;
      int g;
      logic [1:0] le;
      xmovaddr = 10'd19;
      cyc();
      checks++; if (asteroid_on !== 1'b1) begin errors++; $display("FAIL exit_19_on: got %0b expected 1", asteroid_on); end
      checks++; if (passed_count !== 8'd0) begin errors++; $display("FAIL exit_19_passed: got %0d expected 0", passed_count); end
      xmovaddr = 10'd20;
      cyc();
      checks++; if (asteroid_on !== 1'b0) begin errors++; $display("FAIL exit_20_on: got %0b expected 0", asteroid_on); end
      checks++; if (passed_count !== 8'd1) begin errors++; $display("FAIL exit_20_passed: got %0d expected 1", passed_count); end
      g = 2 + int'(lfsr_m[5:0]);
      xmovaddr = 10'd0;
      wait_spawn(n, le);
      checks++; if (n !== 1 + 4 * g) begin errors++; $display("FAIL exit_regap: got %0d cycles expected %0d", n, 1 + 4 * g); end
      checks++; if (lane !== le) begin errors++; $display("FAIL exit_relane: got %0d expected %0d", lane, le); end
   endtask

   task automatic test_hit();
      logic [1:0] lane_held;
      lane_held = lane;
      xmovaddr = 10'd20;
      collide = 1'b1;
      cyc();
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %0b expected 1", hit); end
      checks++; if (asteroid_on !== 1'b1) begin errors++; $display("FAIL hit_on: got %0b expected 1", asteroid_on); end
      checks++; if (passed_count !== 8'd1) begin errors++; $display("FAIL hit_passed: got %0d expected 1", passed_count); end
      collide = 1'b0;
      cyc();
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_single: got %0b expected 0", hit); end
      collide = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_ignored: got %0b expected 0", hit); end
      checks++; if (asteroid_on !== 1'b1) begin errors++; $display("FAIL hit_hold_on: got %0b expected 1", asteroid_on); end
      checks++; if (lane !== lane_held) begin errors++; $display("FAIL hit_hold_lane: got %0d expected %0d", lane, lane_held); end
      checks++; if (passed_count !== 8'd1) begin errors++; $display("FAIL hit_hold_passed: got %0d expected 1", passed_count); end
   endtask

   task automatic test_reset_in_hit();
      int n;
      logic [1:0] le;
      halt = 1'b1;
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      halt = 1'b0;
      collide = 1'b0;
      xmovaddr = 10'd0;
      checks++; if (asteroid_on !== 1'b0) begin errors++; $display("FAIL hitrst_on: got %0b expected 0", asteroid_on); end
      checks++; if (passed_count !== 8'd0) begin errors++; $display("FAIL hitrst_passed: got %0d expected 0", passed_count); end
      checks++; if (lane !== 2'd0) begin errors++; $display("FAIL hitrst_lane: got %0d expected 0", lane); end
      wait_spawn(n, le);
      checks++; if (n !== 8) begin errors++; $display("FAIL hitrst_latency: got %0d expected 8", n); end
      checks++; if (lane !== le) begin errors++; $display("FAIL hitrst_seed_lane: got %0d expected %0d", lane, le); end
   endtask

   task automatic test_halt();
      int n;
      logic [1:0] le;
      do_reset();
      for (int i = 0; i < 3; i++) cyc();
      halt = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      checks++; if (asteroid_on !== 1'b0) begin errors++; $display("FAIL halt_wait_on: got %0b expected 0", asteroid_on); end
      halt = 1'b0;
      wait_spawn(n, le);
      checks++; if (n !== 5) begin errors++; $display("FAIL halt_spawn_delay: got %0d expected 5", n); end
      checks++; if (lane !== le) begin errors++; $display("FAIL halt_lane: got %0d expected %0d", lane, le); end
      halt = 1'b1;
      collide = 1'b1;
      xmovaddr = 10'd20;
      cyc();
      cyc();
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL halt_hit_forced: got %0b expected 0", hit); end
      checks++; if (asteroid_on !== 1'b1) begin errors++; $display("FAIL halt_active_on: got %0b expected 1", asteroid_on); end
      checks++; if (passed_count !== 8'd0) begin errors++; $display("FAIL halt_no_exit: got %0d expected 0", passed_count); end
      halt = 1'b0;
      collide = 1'b0;
      cyc();
      checks++; if (asteroid_on !== 1'b0) begin errors++; $display("FAIL halt_resume_exit_on: got %0b expected 0", asteroid_on); end
      checks++; if (passed_count !== 8'd1) begin errors++; $display("FAIL halt_resume_passed: got %0d expected 1", passed_count); end
      xmovaddr = 10'd0;
   endtask

   task automatic test_wrap();
      int n;
      int timeouts;
      logic [1:0] le;
      timeouts = 0;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         wait_spawn(n, le);
         if (n >= 400) timeouts++;
         xmovaddr = 10'd20;
         cyc();
         xmovaddr = 10'd0;
         if (i == 254) begin
            checks++; if (passed_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", passed_count); end
         end
      end
      checks++; if (passed_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", passed_count); end
      checks++; if (timeouts !== 0) begin errors++; $display("FAIL wrap_spawn_timeout: got %0d expected 0", timeouts); end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_exit();
      test_hit();
      test_reset_in_hit();
      test_halt();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
